// File: rtl/regfile_write_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : wb_arb_pkg
// Purpose  : Shared constants and the pending-write entry type for the
//            regfile write arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_arb_pkg;

    localparam logic [4:0]  c_RSTATUS_REG_DEFAULT = 5'd30;
    localparam logic [31:0] c_MULT_EXC_CODE       = 32'd4;
    localparam logic [31:0] c_DIV_EXC_CODE        = 32'd5;

    // 'reg' is a reserved word, so the destination field is named regnum.
    typedef struct packed {
        logic        live;
        logic [4:0]  regnum;
        logic [31:0] data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : regfile_write_arbiter_if
// Purpose  : W-stage, multdiv, decode-query and regfile-port bundle.
//            Optional forwarding outputs exist only under WB_ARB_FWD_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface regfile_write_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic               w_we;
    logic [4:0]         w_reg;
    logic [31:0]        w_data;
    logic               md_valid;
    logic [4:0]         md_reg;
    logic [31:0]        md_data;
    logic               md_exception;
    logic               md_is_div;
    logic [4:0]         rd_regA;
    logic [4:0]         rd_regB;
    logic               hazard_A;
    logic               hazard_B;
    logic               md_full;
    logic [c_CNT_W-1:0] md_count;
    logic               overflow_err;
    logic               ctrl_writeEnable;
    logic [4:0]         ctrl_writeReg;
    logic [31:0]        data_writeReg;
`ifdef WB_ARB_FWD_EN
    logic [31:0]        fwd_dataA;
    logic [31:0]        fwd_dataB;
`endif

    modport master (
        output w_we,
        output w_reg,
        output w_data,
        output md_valid,
        output md_reg,
        output md_data,
        output md_exception,
        output md_is_div,
        output rd_regA,
        output rd_regB,
        input  hazard_A,
        input  hazard_B,
        input  md_full,
        input  md_count,
        input  overflow_err,
        input  ctrl_writeEnable,
        input  ctrl_writeReg,
        input  data_writeReg
`ifdef WB_ARB_FWD_EN
        ,
        input  fwd_dataA,
        input  fwd_dataB
`endif
    );

    modport slave (
        input  w_we,
        input  w_reg,
        input  w_data,
        input  md_valid,
        input  md_reg,
        input  md_data,
        input  md_exception,
        input  md_is_div,
        input  rd_regA,
        input  rd_regB,
        output hazard_A,
        output hazard_B,
        output md_full,
        output md_count,
        output overflow_err,
        output ctrl_writeEnable,
        output ctrl_writeReg,
        output data_writeReg
`ifdef WB_ARB_FWD_EN
        ,
        output fwd_dataA,
        output fwd_dataB
`endif
    );

endinterface

`default_nettype wire

// File: rtl/regfile_write_arbiter_pending_queue.sv
//------------------------------------------------------------------------------
// Module   : wb_pending_queue
// Purpose  : Circular FIFO of pending multdiv writes with kill-by-register,
//            live-entry match queries and occupancy count (WB_ARB_FWD_EN adds
//            youngest-match data outputs).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_pending_queue
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_push,
    input  wire wb_entry_t                    i_push_entry,
    input  wire logic                         i_pop,
    input  wire logic                         i_kill_en,
    input  wire logic [4:0]                   i_kill_reg,
    input  wire logic [4:0]                   i_query_a,
    input  wire logic [4:0]                   i_query_b,
    output wb_entry_t                         o_head,
    output logic                              o_empty,
    output logic                              o_full,
    output logic [$clog2(DEPTH + 1)-1:0]      o_count,
    output logic                              o_hit_a,
    output logic                              o_hit_b
`ifdef WB_ARB_FWD_EN
    ,
    output logic [31:0]                       o_fwd_a,
    output logic [31:0]                       o_fwd_b
`endif
);

    localparam int                 c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    wb_entry_t          r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_pop) begin
                r_head <= ptr_inc(r_head);
            end
            if (i_push) begin
                r_tail <= ptr_inc(r_tail);
            end
            r_count <= r_count + c_CNT_W'(i_push) - c_CNT_W'(i_pop);
        end
    end

    // Free slots always hold live=0, so match logic needs no occupancy mask.
    // A push into the slot being popped (full queue) must win over the clear.
    generate
        for (genvar j = 0; j < DEPTH; j++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[j] <= '0;
                end else if (i_push && (r_tail == c_PTR_W'(j))) begin
                    r_mem[j] <= i_push_entry;
                end else if (i_pop && (r_head == c_PTR_W'(j))) begin
                    r_mem[j].live <= 1'b0;
                end else if (i_kill_en && r_mem[j].live && (r_mem[j].regnum == i_kill_reg)) begin
                    r_mem[j].live <= 1'b0;
                end
            end
        end
    endgenerate

    assign o_head  = r_mem[r_head];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_DEPTH);
    assign o_count = r_count;

    always_comb begin
        o_hit_a = 1'b0;
        o_hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].live && (i_query_a != 5'd0) && (r_mem[i].regnum == i_query_a)) begin
                o_hit_a = 1'b1;
            end
            if (r_mem[i].live && (i_query_b != 5'd0) && (r_mem[i].regnum == i_query_b)) begin
                o_hit_b = 1'b1;
            end
        end
    end

`ifdef WB_ARB_FWD_EN
    logic [c_PTR_W-1:0] w_walk;

    // Walk oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        o_fwd_a = '0;
        o_fwd_b = '0;
        w_walk  = r_head;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[w_walk].live && (i_query_a != 5'd0) && (r_mem[w_walk].regnum == i_query_a)) begin
                o_fwd_a = r_mem[w_walk].data;
            end
            if (r_mem[w_walk].live && (i_query_b != 5'd0) && (r_mem[w_walk].regnum == i_query_b)) begin
                o_fwd_b = r_mem[w_walk].data;
            end
            w_walk = ptr_inc(w_walk);
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : regfile_write_arbiter
// Purpose  : Owns the regfile write port; W-stage writes win, multdiv results
//            bypass or park in a pending queue. Macro WB_ARB_FWD_EN adds
//            fwd_dataA/fwd_dataB forwarding outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int          DEPTH         = 2,
    parameter logic [4:0]  RSTATUS_REG   = c_RSTATUS_REG_DEFAULT,
    parameter logic [31:0] MULT_EXC_CODE = c_MULT_EXC_CODE,
    parameter logic [31:0] DIV_EXC_CODE  = c_DIV_EXC_CODE
) (
    input  wire logic              clock,
    input  wire logic              reset,
    regfile_write_arbiter_if.slave bus
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          w_md_entry;
    wb_entry_t          w_head;
    logic               w_w_busy;
    logic               w_md_ok;
    logic               w_head_live;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_bypass;
    logic               w_drop;
    logic               w_hit_a;
    logic               w_hit_b;
    logic [c_CNT_W-1:0] w_count;
    logic               r_overflow_err;

    always_comb begin
        w_md_entry.live = 1'b1;
        if (bus.md_exception) begin
            w_md_entry.regnum = RSTATUS_REG;
            w_md_entry.data   = bus.md_is_div ? DIV_EXC_CODE : MULT_EXC_CODE;
        end else begin
            w_md_entry.regnum = bus.md_reg;
            w_md_entry.data   = bus.md_data;
        end
    end

    // A write to r0 is architecturally a no-op, so it leaves the port free.
    assign w_w_busy    = bus.w_we && (bus.w_reg != 5'd0);
    assign w_md_ok     = bus.md_valid && (bus.md_exception || (bus.md_reg != 5'd0));
    assign w_head_live = !w_empty && w_head.live;

    assign w_pop    = !reset && !w_empty && (!w_head.live || !w_w_busy);
    assign w_bypass = !reset && w_md_ok && w_empty && !w_w_busy;
    assign w_push   = !reset && w_md_ok && !w_bypass && (!w_full || w_pop);
    assign w_drop   = !reset && w_md_ok && !w_bypass && w_full && !w_pop;

    wb_pending_queue #(
        .DEPTH        (DEPTH)
    ) u_queue (
        .clk          (clock),
        .rst          (reset),
        .i_push       (w_push),
        .i_push_entry (w_md_entry),
        .i_pop        (w_pop),
        .i_kill_en    (!reset && w_w_busy),
        .i_kill_reg   (bus.w_reg),
        .i_query_a    (bus.rd_regA),
        .i_query_b    (bus.rd_regB),
        .o_head       (w_head),
        .o_empty      (w_empty),
        .o_full       (w_full),
        .o_count      (w_count),
        .o_hit_a      (w_hit_a),
        .o_hit_b      (w_hit_b)
`ifdef WB_ARB_FWD_EN
        ,
        .o_fwd_a      (bus.fwd_dataA),
        .o_fwd_b      (bus.fwd_dataB)
`endif
    );

    always_comb begin
        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_writeReg    = '0;
        bus.data_writeReg    = '0;
        if (!reset) begin
            if (w_w_busy) begin
                bus.ctrl_writeEnable = 1'b1;
                bus.ctrl_writeReg    = bus.w_reg;
                bus.data_writeReg    = bus.w_data;
            end else if (w_head_live) begin
                bus.ctrl_writeEnable = 1'b1;
                bus.ctrl_writeReg    = w_head.regnum;
                bus.data_writeReg    = w_head.data;
            end else if (w_bypass) begin
                bus.ctrl_writeEnable = 1'b1;
                bus.ctrl_writeReg    = w_md_entry.regnum;
                bus.data_writeReg    = w_md_entry.data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow_err <= 1'b0;
        end else if (w_drop) begin
            r_overflow_err <= 1'b1;
        end
    end

    assign bus.hazard_A     = !reset && w_hit_a;
    assign bus.hazard_B     = !reset && w_hit_b;
    assign bus.md_full      = w_full;
    assign bus.md_count     = w_count;
    assign bus.overflow_err = r_overflow_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed plus randomized bench for regfile_write_arbiter against
//            a queue-based reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_write_arbiter;

    localparam int c_DEPTH = 2;

    typedef struct {
        bit          live;
        logic [4:0]  regnum;
        logic [31:0] data;
    } mentry_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    regfile_write_arbiter_if #(.DEPTH(c_DEPTH)) bus ();

    regfile_write_arbiter #(.DEPTH(c_DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    mentry_t q[$];
    bit      m_ovf = 1'b0;
    int      n_checks = 0;
    int      n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_match(input logic [4:0] r, output logic [31:0] d);
        bit hit = 1'b0;
        d = '0;
        if (r != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].live && q[i].regnum == r) begin
                    hit = 1'b1;
                    d   = q[i].data;
                end
            end
        end
        return hit;
    endfunction

    // One cycle: drive inputs, compare outputs against the model, advance model.
    task automatic step(input bit rst, input bit we, input logic [4:0] wreg, input logic [31:0] wdata,
                        input bit mv, input logic [4:0] mreg, input logic [31:0] mdata,
                        input bit mexc, input bit mdiv, input logic [4:0] ra, input logic [4:0] rb);
        bit          w_busy, m_ok, head_pop, bypass, was_full, exp_we, hit_a, hit_b;
        logic [4:0]  nreg, exp_reg;
        logic [31:0] ndata, exp_data, fa, fb;
        @(negedge clock);
        reset            = rst;
        bus.w_we         = we;
        bus.w_reg        = wreg;
        bus.w_data       = wdata;
        bus.md_valid     = mv;
        bus.md_reg       = mreg;
        bus.md_data      = mdata;
        bus.md_exception = mexc;
        bus.md_is_div    = mdiv;
        bus.rd_regA      = ra;
        bus.rd_regB      = rb;
        #1;
        if (rst) begin
            check_eq("we_in_reset", 32'(bus.ctrl_writeEnable), 32'd0);
            check_eq("hazA_in_reset", 32'(bus.hazard_A), 32'd0);
            check_eq("hazB_in_reset", 32'(bus.hazard_B), 32'd0);
            q.delete();
            m_ovf = 1'b0;
            return;
        end
        w_busy = we && (wreg != 5'd0);
        m_ok   = mv && (mexc || (mreg != 5'd0));
        nreg   = mexc ? 5'd30 : mreg;
        ndata  = mexc ? (mdiv ? 32'd5 : 32'd4) : mdata;
        bypass = !w_busy && (q.size() == 0) && m_ok;
        exp_we = 1'b1; exp_reg = '0; exp_data = '0;
        if (w_busy) begin
            exp_reg = wreg; exp_data = wdata;
        end else if (q.size() > 0 && q[0].live) begin
            exp_reg = q[0].regnum; exp_data = q[0].data;
        end else if (bypass) begin
            exp_reg = nreg; exp_data = ndata;
        end else begin
            exp_we = 1'b0;
        end
        check_eq("write_enable", 32'(bus.ctrl_writeEnable), 32'(exp_we));
        if (exp_we) begin
            check_eq("write_reg", 32'(bus.ctrl_writeReg), 32'(exp_reg));
            check_eq("write_data", bus.data_writeReg, exp_data);
        end
        hit_a = model_match(ra, fa);
        hit_b = model_match(rb, fb);
        check_eq("hazard_A", 32'(bus.hazard_A), 32'(hit_a));
        check_eq("hazard_B", 32'(bus.hazard_B), 32'(hit_b));
`ifdef WB_ARB_FWD_EN
        check_eq("fwd_dataA", bus.fwd_dataA, fa);
        check_eq("fwd_dataB", bus.fwd_dataB, fb);
`endif
        check_eq("md_count", 32'(bus.md_count), 32'(q.size()));
        check_eq("md_full", 32'(bus.md_full), 32'(q.size() == c_DEPTH));
        check_eq("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
        head_pop = (q.size() > 0) && (!q[0].live || !w_busy);
        was_full = (q.size() == c_DEPTH);
        if (w_busy) begin
            foreach (q[i]) begin
                if (q[i].regnum == wreg) q[i].live = 1'b0;
            end
        end
        if (head_pop) void'(q.pop_front());
        if (m_ok && !bypass) begin
            if (!was_full || head_pop) q.push_back('{1'b1, nreg, ndata});
            else m_ovf = 1'b1;
        end
    endtask

    task automatic idle(input logic [4:0] ra);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, ra, 5'd0);
    endtask

    initial begin
        bus.w_we = 1'b0; bus.w_reg = '0; bus.w_data = '0;
        bus.md_valid = 1'b0; bus.md_reg = '0; bus.md_data = '0;
        bus.md_exception = 1'b0; bus.md_is_div = 1'b0;
        bus.rd_regA = '0; bus.rd_regB = '0;

        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 5'd0);
        step(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 0, 5'd0, 5'd0);
        idle(5'd0);
        check_eq("reset_count", 32'(bus.md_count), 32'd0);

        // Bypass
        step(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'h1234, 0, 0, 5'd5, 5'd0);
        check_eq("bypass_reg", 32'(bus.ctrl_writeReg), 32'd5);
        check_eq("bypass_data", bus.data_writeReg, 32'h1234);
        idle(5'd5);
        check_eq("bypass_count", 32'(bus.md_count), 32'd0);

        // Collision: W wins, multdiv result drains next idle cycle
        step(0, 1, 5'd3, 32'd7, 1, 5'd4, 32'd9, 0, 0, 5'd4, 5'd0);
        check_eq("coll_w_data", bus.data_writeReg, 32'd7);
        idle(5'd4);
        check_eq("coll_haz", 32'(bus.hazard_A), 32'd1);
        check_eq("coll_md_data", bus.data_writeReg, 32'd9);
        idle(5'd4);

        // WAW kill
        step(0, 1, 5'd3, 32'd7, 1, 5'd4, 32'd9, 0, 0, 5'd4, 5'd0);
        step(0, 1, 5'd4, 32'd1, 0, 5'd0, 32'd0, 0, 0, 5'd4, 5'd0);
        check_eq("waw_w_data", bus.data_writeReg, 32'd1);
        idle(5'd4);
        check_eq("waw_dead_we", 32'(bus.ctrl_writeEnable), 32'd0);
        check_eq("waw_dead_haz", 32'(bus.hazard_A), 32'd0);
        idle(5'd4);
        check_eq("waw_count", 32'(bus.md_count), 32'd0);

        // Exceptions
        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'hdead, 1, 1, 5'd0, 5'd0);
        check_eq("exc_div_reg", 32'(bus.ctrl_writeReg), 32'd30);
        check_eq("exc_div_data", bus.data_writeReg, 32'd5);
        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'hbeef, 1, 0, 5'd0, 5'd0);
        check_eq("exc_mult_data", bus.data_writeReg, 32'd4);

        // Full and overflow, then reset recovery
        step(0, 1, 5'd1, 32'd11, 1, 5'd6, 32'd60, 0, 0, 5'd6, 5'd7);
        step(0, 1, 5'd1, 32'd12, 1, 5'd7, 32'd70, 0, 0, 5'd6, 5'd7);
        step(0, 1, 5'd1, 32'd13, 1, 5'd8, 32'd80, 0, 0, 5'd8, 5'd7);
        check_eq("full_flag", 32'(bus.md_full), 32'd1);
        step(0, 1, 5'd1, 32'd14, 0, 5'd0, 32'd0, 0, 0, 5'd8, 5'd0);
        check_eq("ovf_set", 32'(bus.overflow_err), 32'd1);
        check_eq("ovf_dropped_haz", 32'(bus.hazard_A), 32'd0);
        step(1, 1, 5'd2, 32'd15, 1, 5'd9, 32'd1, 0, 0, 5'd6, 5'd0);
        idle(5'd6);
        check_eq("rst_count", 32'(bus.md_count), 32'd0);
        check_eq("rst_ovf", 32'(bus.overflow_err), 32'd0);

        // Zero register
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h55, 0, 0, 5'd0, 5'd0);
        check_eq("zero_md_we", 32'(bus.ctrl_writeEnable), 32'd0);
        idle(5'd0);
        check_eq("zero_md_count", 32'(bus.md_count), 32'd0);
        step(0, 1, 5'd3, 32'd2, 1, 5'd9, 32'h99, 0, 0, 5'd0, 5'd0);
        step(0, 1, 5'd0, 32'hff, 0, 5'd0, 32'd0, 0, 0, 5'd9, 5'd0);
        check_eq("zero_w_drain_reg", 32'(bus.ctrl_writeReg), 32'd9);
        check_eq("zero_w_drain_data", bus.data_writeReg, 32'h99);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(63) == 0),
                 1'($urandom_range(1)), 5'($urandom_range(7)), $urandom,
                 ($urandom_range(9) < 4), 5'($urandom_range(7)), $urandom,
                 ($urandom_range(7) == 0), 1'($urandom_range(1)),
                 ($urandom_range(5) == 0) ? 5'd30 : 5'($urandom_range(7)),
                 5'($urandom_range(7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
